// File: rtl/alu_rr_scheduler_if.sv
// Request, ALU and response signals between the two requesters, the shared ALU
// and the round-robin scheduler that sits between them.
interface alu_rr_scheduler_if #(
  parameter int DW  = 4,
  parameter int OPW = 8,
  parameter int RW  = 8
);
  logic           req0_valid;
  logic           req0_ready;
  logic [OPW-1:0] req0_op;
  logic [DW-1:0]  req0_a;
  logic [DW-1:0]  req0_b;

  logic           req1_valid;
  logic           req1_ready;
  logic [OPW-1:0] req1_op;
  logic [DW-1:0]  req1_a;
  logic [DW-1:0]  req1_b;

  logic [DW-1:0]  alu_x;
  logic [DW-1:0]  alu_y;
  logic [OPW-1:0] alu_op;
  logic [RW-1:0]  alu_result;

  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [RW-1:0]  rsp_data;
  logic           rsp_err;

  // Scheduler side
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output alu_x, alu_y, alu_op,
    input  alu_result,
    output rsp_valid, rsp_id, rsp_data, rsp_err,
    input  rsp_ready
  );

  // Requester / ALU / consumer side
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  alu_x, alu_y, alu_op,
    output alu_result,
    input  rsp_valid, rsp_id, rsp_data, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin sharing of one combinational ALU between two requesters:
// accept -> issue (registered operands) -> response held until handshake.
module alu_rr_scheduler #(
  parameter int DW     = 4,
  parameter int OPW    = 8,
  parameter int RW     = 8,
  parameter int MAX_OP = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  alu_rr_scheduler_if.slave  bus,
  output logic [7:0]         ops_done
);

  localparam logic [OPW-1:0] OP_LIMIT = OPW'(MAX_OP);
  localparam logic [OPW-1:0] OP_DIV   = OPW'(3);
  localparam logic [OPW-1:0] OP_MOD   = OPW'(10);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t         state_reg;
  state_t         state_next;

  logic [1:0]     valid;
  logic [1:0]     ready;
  logic [OPW-1:0] op_in [2];
  logic [DW-1:0]  a_in  [2];
  logic [DW-1:0]  b_in  [2];

  logic           grant;
  logic           grant_valid;
  logic           last_grant_reg;

  logic [DW-1:0]  alu_x_reg;
  logic [DW-1:0]  alu_y_reg;
  logic [OPW-1:0] alu_op_reg;
  logic           rsp_valid_reg;
  logic           rsp_id_reg;
  logic [RW-1:0]  rsp_data_reg;
  logic           rsp_err_reg;
  logic [7:0]     ops_done_reg;

  logic           op_illegal;
  logic           div_by_zero;
  logic           op_err;

  assign valid    = {bus.req1_valid, bus.req0_valid};
  assign op_in[0] = bus.req0_op;
  assign a_in[0]  = bus.req0_a;
  assign b_in[0]  = bus.req0_b;
  assign op_in[1] = bus.req1_op;
  assign a_in[1]  = bus.req1_a;
  assign b_in[1]  = bus.req1_b;

  // Grant depends only on valids, state, ena and the pointer, never on ready.
  always_comb begin
    grant       = 1'b0;
    grant_valid = 1'b0;
    if (state_reg == IDLE && ena) begin
      case (valid)
        2'b01: begin
          grant       = 1'b0;
          grant_valid = 1'b1;
        end
        2'b10: begin
          grant       = 1'b1;
          grant_valid = 1'b1;
        end
        2'b11: begin
          grant       = ~last_grant_reg;
          grant_valid = 1'b1;
        end
        default: begin
          grant       = 1'b0;
          grant_valid = 1'b0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign ready[gi] = grant_valid && (grant == 1'(gi));
    end
  endgenerate

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];

  // Errors are judged on the registered op so they line up with alu_result.
  assign op_illegal  = (alu_op_reg > OP_LIMIT);
  assign div_by_zero = ((alu_op_reg == OP_DIV) || (alu_op_reg == OP_MOD)) && (alu_y_reg == '0);
  assign op_err      = op_illegal || div_by_zero;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_valid) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_x_reg      <= '0;
      alu_y_reg      <= '0;
      alu_op_reg     <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= 1'b0;
      rsp_data_reg   <= '0;
      rsp_err_reg    <= 1'b0;
      ops_done_reg   <= 8'd0;
      last_grant_reg <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            alu_x_reg      <= a_in[grant];
            alu_y_reg      <= b_in[grant];
            alu_op_reg     <= op_in[grant];
            rsp_id_reg     <= grant;
            last_grant_reg <= grant;
          end
        end
        ISSUE: begin
          rsp_valid_reg <= 1'b1;
          rsp_err_reg   <= op_err;
          rsp_data_reg  <= op_err ? '0 : bus.alu_result;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            ops_done_reg  <= ops_done_reg + 8'd1;
          end
        end
        default: begin
          rsp_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.alu_x     = alu_x_reg;
  assign bus.alu_y     = alu_y_reg;
  assign bus.alu_op    = alu_op_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign ops_done      = ops_done_reg;

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one combinational 4-bit ALU (8-bit opcode select, 8-bit result) between two requesters.
- Arbitrates round-robin, drives the ALU operand and opcode lines from registers, and captures the result.
- Returns the result with requester ID and error flag over a valid/ready response channel.
- Sits between the input/control logic and the shared ALU datapath; keeps a wrapping completed-operation counter.

Parameters:
- DW, 4, operand width (x, y)
- OPW, 8, opcode width
- RW, 8, result width
- MAX_OP, 12, highest legal opcode

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ena  in  1  grant enable; low blocks new grants, in-flight op completes
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_op  in  OPW  requester 0 opcode
- req0_a  in  DW  requester 0 operand x
- req0_b  in  DW  requester 0 operand y
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
- alu_x  out  DW  registered ALU operand x
- alu_y  out  DW  registered ALU operand y
- alu_op  out  OPW  registered ALU opcode
- alu_result  in  RW  combinational ALU result
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the op
- rsp_data  out  RW  captured result
- rsp_err  out  1  op rejected (illegal opcode or divide/modulo by zero)
- ops_done  out  8  completed responses, wraps 255->0

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=IDLE; all outputs 0 (alu_x, alu_y, alu_op, rsp_*, ops_done, both ready).
  - Round-robin pointer last_grant=1, so req0 wins the first contention.
  - Reset mid-operation discards the transaction; no response is produced.
- FSM states:
  - IDLE: accept one request.
  - ISSUE: ALU inputs stable, result evaluated.
  - RESP: hold response until handshake.
- Grant (combinational, IDLE only and ena=1):
  - Exactly one valid requester: it is granted.
  - Both valid: the requester != last_grant is granted.
  - reqN_ready = (state==IDLE) & ena & grant==N; at most one ready high per cycle.
  - Ready never depends on a ready signal of the same channel.
- Accept edge (valid&ready, cycle T):
  - Load alu_x, alu_y, alu_op and rsp_id from the granted requester.
  - last_grant <= granted id; state <= ISSUE.
- ISSUE (cycle T+1):
  - Edge ending ISSUE: rsp_data <= alu_result, unless an error applies.
  - state <= RESP; rsp_valid=1 from cycle T+2.
- Error rules, checked on the registered op:
  - alu_op > MAX_OP -> rsp_err=1, rsp_data=0.
  - alu_op in {3,10} with alu_y==0 -> rsp_err=1, rsp_data=0.
  - Otherwise rsp_err=0 and rsp_data=alu_result.
- RESP:
  - rsp_valid, rsp_id, rsp_data and rsp_err stay stable until rsp_ready=1.
  - On handshake edge: rsp_valid <= 0, ops_done <= ops_done+1 (errored ops count too), state <= IDLE.
  - No request is accepted in the handshake cycle; earliest next accept is the following cycle.
  - Issue period is therefore 3 cycles minimum per op.
- alu_x, alu_y and alu_op hold their last issued values outside ISSUE.
- ena low during ISSUE/RESP has no effect on completion; ena low in IDLE keeps both ready low.
- Requesters must hold op, a and b stable while valid and not ready; the block samples only on the accept edge.

Test Plan:
- Single add: req0 op=0 a=3 b=5, bench ALU model -> alu_x=3, alu_y=5 at T+1; rsp_valid at T+2 with rsp_id=0, rsp_data=0x08, rsp_err=0; ops_done=1 after handshake.
- Contention: req0 and req1 both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; first response rsp_id=0; req0_ready and req1_ready never both high.
- Subtract sign and backpressure: req1 op=1 a=2 b=7, rsp_ready low 5 cycles -> rsp_data=0xFB held stable for all 5 cycles with rsp_valid=1; both ready signals stay low until the handshake.
- Errors: op=3 b=0 -> rsp_err=1, rsp_data=0x00; op=13 -> rsp_err=1, rsp_data=0x00; op=10 a=9 b=4 -> rsp_err=0, rsp_data=0x01; ops_done increments for all three.
- Reset and ena:
  - rst_n low during ISSUE -> next cycle all outputs 0 and no response; first post-reset contention grants req0.
  - ena=0 with req0 valid -> req0_ready stays 0.
- Wrap: 256 completed ops -> ops_done returns to 0x00.
